// File: rtl/ramp_gen_pkg.sv
// ramp_gen_pkg: state encoding, fraction width and default widths for the ramp generator
package ramp_gen_pkg;
  localparam int FRAC_BITS = 16;
  localparam int DEF_SIGNAL_OUT_SIZE = 16;
  localparam int DEF_STEP_SIZE = 32;
  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
endpackage

// File: rtl/ramp_gen_sat_acc.sv
// ramp_gen_sat_acc: one accumulator step (add or subtract) with guard bits,
// clamped to [min, max]; the input is first pulled inside freshly loaded bounds.
module ramp_gen_sat_acc
  import ramp_gen_pkg::*;
#(
  parameter int SIGNAL_OUT_SIZE = DEF_SIGNAL_OUT_SIZE,
  parameter int STEP_SIZE = DEF_STEP_SIZE
) (
  input  logic signed [SIGNAL_OUT_SIZE+FRAC_BITS-1:0] i_acc,
  input  logic        [STEP_SIZE-1:0]                 i_step,
  input  logic signed [SIGNAL_OUT_SIZE-1:0]           i_min,
  input  logic signed [SIGNAL_OUT_SIZE-1:0]           i_max,
  input  logic                                        i_down,
  output logic signed [SIGNAL_OUT_SIZE+FRAC_BITS-1:0] o_acc,
  output logic                                        o_over
);
  localparam int AW = SIGNAL_OUT_SIZE + FRAC_BITS;
  localparam int W = (AW > STEP_SIZE ? AW : STEP_SIZE) + 2;
  logic signed [W-1:0] w_lo, w_hi, w_a, w_c, w_s, w_n;
  assign w_lo = {{(W-AW){i_min[SIGNAL_OUT_SIZE-1]}}, i_min, {FRAC_BITS{1'b0}}};
  assign w_hi = {{(W-AW){i_max[SIGNAL_OUT_SIZE-1]}}, i_max, {FRAC_BITS{1'b0}}};
  assign w_a = {{(W-AW){i_acc[AW-1]}}, i_acc};
  assign w_c = w_a < w_lo ? w_lo : w_a > w_hi ? w_hi : w_a;
  assign w_s = {{(W-STEP_SIZE){1'b0}}, i_step};
  assign w_n = i_down ? w_c - w_s : w_c + w_s;
  assign o_over = i_down ? w_n < w_lo : w_n > w_hi;
  assign o_acc = o_over ? (i_down ? w_lo[AW-1:0] : w_hi[AW-1:0]) : w_n[AW-1:0];
endmodule

// File: rtl/ramp_gen.sv
// ramp_gen: sawtooth/triangle ramp for a DAC with shadowed bounds and step.
// Define RAMP_GEN_TRIANGLE_EN for triangle sweeps; the default build is sawtooth.
module ramp_gen
  import ramp_gen_pkg::*;
#(
  parameter int SIGNAL_OUT_SIZE = DEF_SIGNAL_OUT_SIZE,
  parameter int STEP_SIZE = DEF_STEP_SIZE
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              on_in,
  input  logic                              load_in,
  input  logic signed [SIGNAL_OUT_SIZE-1:0] minval_in,
  input  logic signed [SIGNAL_OUT_SIZE-1:0] maxval_in,
  input  logic        [STEP_SIZE-1:0]       stepsize_in,
  output logic signed [SIGNAL_OUT_SIZE-1:0] signal_out,
  output logic                              dir_out,
  output logic                              wrap_out,
  output logic                              err_out
);
  localparam int AW = SIGNAL_OUT_SIZE + FRAC_BITS;
  state_t r_state, w_state;
  logic signed [AW-1:0] r_acc, w_acc, w_step_acc, w_lo;
  logic signed [SIGNAL_OUT_SIZE-1:0] r_min, r_max, w_min, w_max;
  logic [STEP_SIZE-1:0] r_step, w_step;
  logic r_err, w_err, r_dir, w_dir, r_wrap, w_wrap, w_ld, w_over;
  // Parameters loading this cycle are used immediately, so a start or load
  // in the same cycle already sees the new bounds.
  assign w_ld = load_in || r_state == IDLE;
  assign w_min = w_ld ? minval_in : r_min;
  assign w_max = w_ld ? maxval_in : r_max;
  assign w_step = w_ld ? stepsize_in : r_step;
  assign w_err = w_ld ? minval_in >= maxval_in : r_err;
  assign w_lo = {w_min, {FRAC_BITS{1'b0}}};
  ramp_gen_sat_acc #(
    .SIGNAL_OUT_SIZE(SIGNAL_OUT_SIZE),
    .STEP_SIZE(STEP_SIZE)
  ) u_acc (
    .i_acc(r_acc),
    .i_step(w_step),
    .i_min(w_min),
    .i_max(w_max),
    .i_down(r_state == DOWN),
    .o_acc(w_step_acc),
    .o_over(w_over)
  );
  always_comb begin
    w_state = r_state;
    w_acc = r_acc;
    w_dir = r_dir;
    w_wrap = 1'b0;
    if (w_err) begin
      w_state = IDLE;
      w_acc = w_lo;
    end else if (r_state == IDLE) begin
      if (on_in) begin
        w_state = UP;
        w_acc = w_lo;
        w_dir = 1'b1;
      end
    end else if (!on_in) begin
      w_state = IDLE;
    end else begin
      w_acc = w_step_acc;
      if (w_over && r_state == DOWN) begin
        w_state = UP;
        w_dir = 1'b1;
        w_wrap = 1'b1;
      end
`ifdef RAMP_GEN_TRIANGLE_EN
      else if (w_over) begin
        w_state = DOWN;
        w_dir = 1'b0;
      end
`else
      else if (w_over) begin
        w_acc = w_lo;
        w_wrap = 1'b1;
      end
`endif
    end
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_acc <= '0;
      r_dir <= 1'b1;
      r_wrap <= 1'b0;
      r_err <= 1'b0;
      r_min <= '0;
      r_max <= '0;
      r_step <= '0;
    end else begin
      r_state <= w_state;
      r_acc <= w_acc;
      r_dir <= w_dir;
      r_wrap <= w_wrap;
      r_err <= w_err;
      r_min <= w_min;
      r_max <= w_max;
      r_step <= w_step;
    end
  end
  assign signal_out = r_acc[AW-1:FRAC_BITS];
  assign dir_out = r_dir;
  assign wrap_out = r_wrap;
  assign err_out = r_err;
endmodule
